// File: rtl/hier_child_gather.sv
// hier_child_gather
//   Parent-side responder for one fan-out node of a hierarchy. Takes a single
//   upstream request, pulses start to every child for one cycle, collects the
//   children's done signals into a sticky mask, then returns one response
//   upstream carrying the completion mask and a timeout flag.
//
// Ports
//   clk          rising-edge clock for all logic
//   rst_n        synchronous reset, active low
//   req_valid    upstream request present
//   req_ready    block can accept a request (IDLE and out of reset)
//   child_start  one-cycle start pulse, identical on every bit
//   child_done   per-child completion, pulse or level
//   rsp_valid    response present upstream
//   rsp_ready    upstream accepts the response
//   rsp_mask     children that reported done during this request
//   rsp_timeout  1 = response produced by timeout rather than full completion
//   busy         high whenever the FSM is not in IDLE
module hier_child_gather #(
  parameter int NUM_CHILDREN   = 5,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  output logic [NUM_CHILDREN-1:0] child_start,
  input  logic [NUM_CHILDREN-1:0] child_done,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [NUM_CHILDREN-1:0] rsp_mask,
  output logic                    rsp_timeout,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [NUM_CHILDREN-1:0] ALL_DONE = '1;
  localparam logic [TO_W-1:0]         CNT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [TO_W-1:0]         cnt;
  logic [TO_W-1:0]         cnt_nxt;
  logic [NUM_CHILDREN-1:0] mask;
  logic [NUM_CHILDREN-1:0] mask_nxt;
  logic                    timeout;
  logic                    timeout_nxt;

  // Sticky accumulation of this cycle's done bits onto the running mask.
  function automatic logic [NUM_CHILDREN-1:0] gather(
    input logic [NUM_CHILDREN-1:0] acc,
    input logic [NUM_CHILDREN-1:0] done
  );
    return acc | done;
  endfunction

  // State register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      mask    <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mask    <= mask_nxt;
      timeout <= timeout_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    mask_nxt    = mask;
    timeout_nxt = timeout;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt   = ST_START;
          cnt_nxt     = '0;
          mask_nxt    = '0;
          timeout_nxt = 1'b0;
        end
      end
      ST_START: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        mask_nxt = gather(mask, child_done);
        cnt_nxt  = cnt + 1'b1;
        // Completion is tested first so it wins over a coincident timeout.
        if (gather(mask, child_done) == ALL_DONE) begin
          state_nxt   = ST_RESP;
          timeout_nxt = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = ST_RESP;
          timeout_nxt = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Moore outputs; the response fields are forced to zero outside RESP so
  // nothing stale is presented upstream while idle or in reset.
  always_comb begin
    req_ready   = rst_n && (state == ST_IDLE);
    child_start = {NUM_CHILDREN{state == ST_START}};
    rsp_valid   = (state == ST_RESP);
    rsp_mask    = (state == ST_RESP) ? mask : '0;
    rsp_timeout = (state == ST_RESP) ? timeout : 1'b0;
    busy        = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_hier_child_gather.sv
module tb_hier_child_gather;

  localparam int NC = 5;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [NC-1:0] child_start;
  logic [NC-1:0] child_done = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [NC-1:0] rsp_mask;
  logic          rsp_timeout;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  hier_child_gather #(
    .NUM_CHILDREN  (NC),
    .TIMEOUT_CYCLES(TO),
    .TO_W          (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .child_start(child_start),
    .child_done (child_done),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_mask   (rsp_mask),
    .rsp_timeout(rsp_timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a request from IDLE; returns positioned in the first WAIT cycle.
  task automatic start_req(input string tag, input logic [NC-1:0] done_in_start);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    tick;
    req_valid  = 1'b0;
    child_done = done_in_start;
    check({tag, " start"}, 32'(child_start), 32'h1f);
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
    tick;
    child_done = '0;
    check({tag, " start one cycle"}, 32'(child_start), 32'h00);
    check({tag, " no early rsp"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check({tag, " back to idle"}, 32'(rsp_valid), 32'd0);
    check({tag, " busy after rsp"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset held with a pending request
    rst_n     = 1'b0;
    req_valid = 1'b1;
    repeat (3) tick;
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst child_start", 32'(child_start), 32'h00);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst rsp_mask", 32'(rsp_mask), 32'h00);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    #1;
    check("post rst req_ready", 32'(req_ready), 32'd1);
    tick;

    // Normal completion: dones at T+2 (two), T+3, T+4, T+5
    start_req("norm", '0);
    child_done = 5'b00011;
    tick;
    check("norm T+3", 32'(rsp_valid), 32'd0);
    child_done = 5'b00100;
    tick;
    check("norm T+4", 32'(rsp_valid), 32'd0);
    child_done = 5'b01000;
    tick;
    check("norm T+5", 32'(rsp_valid), 32'd0);
    child_done = 5'b10000;
    tick;
    child_done = '0;
    check("norm rsp_valid", 32'(rsp_valid), 32'd1);
    check("norm rsp_mask", 32'(rsp_mask), 32'h1f);
    check("norm rsp_timeout", 32'(rsp_timeout), 32'd0);
    handshake("norm");

    // Timeout with only children 0 and 2
    start_req("tmo", '0);
    child_done = 5'b00001;
    tick;
    check("tmo W2", 32'(rsp_valid), 32'd0);
    child_done = 5'b00100;
    tick;
    child_done = '0;
    check("tmo W3", 32'(rsp_valid), 32'd0);
    tick;
    check("tmo W4", 32'(rsp_valid), 32'd0);
    tick;
    check("tmo rsp_valid", 32'(rsp_valid), 32'd1);
    check("tmo rsp_mask", 32'(rsp_mask), 32'h05);
    check("tmo rsp_timeout", 32'(rsp_timeout), 32'd1);

    // Back-pressure: response held, new request stalled, done in RESP ignored
    req_valid  = 1'b1;
    child_done = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp rsp_mask", 32'(rsp_mask), 32'h05);
      check("bp rsp_timeout", 32'(rsp_timeout), 32'd1);
      check("bp req_ready", 32'(req_ready), 32'd0);
    end
    child_done = '0;
    rsp_ready  = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("bp idle rsp_valid", 32'(rsp_valid), 32'd0);

    // Stalled request accepted one cycle after the handshake; done in START ignored
    start_req("simul", 5'b11111);
    child_done = 5'b00001;
    tick;
    check("simul W2", 32'(rsp_valid), 32'd0);
    child_done = 5'b00110;
    tick;
    check("simul W3", 32'(rsp_valid), 32'd0);
    child_done = 5'b01000;
    tick;
    check("simul W4", 32'(rsp_valid), 32'd0);
    child_done = 5'b10000;
    tick;
    child_done = '0;
    check("simul rsp_valid", 32'(rsp_valid), 32'd1);
    check("simul rsp_mask", 32'(rsp_mask), 32'h1f);
    check("simul rsp_timeout", 32'(rsp_timeout), 32'd0);
    handshake("simul");

    // Reset in the middle of WAIT with mask 00011
    start_req("abort", '0);
    child_done = 5'b00011;
    tick;
    child_done = '0;
    rst_n      = 1'b0;
    tick;
    check("abort busy", 32'(busy), 32'd0);
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    tick;
    check("abort still idle", 32'(rsp_valid), 32'd0);

    // Following request must start from an empty mask
    start_req("fresh", '0);
    child_done = 5'b10100;
    tick;
    child_done = '0;
    check("fresh W2", 32'(rsp_valid), 32'd0);
    tick;
    tick;
    check("fresh W4", 32'(rsp_valid), 32'd0);
    tick;
    check("fresh rsp_valid", 32'(rsp_valid), 32'd1);
    check("fresh rsp_mask", 32'(rsp_mask), 32'h14);
    check("fresh rsp_timeout", 32'(rsp_timeout), 32'd1);
    handshake("fresh");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
